// File: rtl/overlay_host_pkg.sv
// Shared constants, derived counter widths and FSM encoding for the overlay host sequencer.
package overlay_host_pkg;

  localparam int PE_NUM      = 8;
  localparam int DATA_WIDTH  = 16;
  localparam int INST_WIDTH  = 32;
  localparam int INST_DEPTH  = 16;
  localparam int COMPUTE_LAT = 12;
  localparam int TIMEOUT     = 64;

  localparam int WORD_WIDTH  = 2 * DATA_WIDTH;
  localparam int INST_AW     = $clog2(INST_DEPTH);
  localparam int INST_NW     = INST_AW + 1;
  localparam int PE_CW       = $clog2(PE_NUM);
  localparam int LAT_CW      = $clog2(COMPUTE_LAT);
  localparam int TO_CW       = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INST  = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_LOAD  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

  // Requests larger than the buffer replay the whole buffer once.
  function automatic logic [INST_NW-1:0] clamp_inst_num(input logic [INST_NW-1:0] n);
    return (n > INST_NW'(INST_DEPTH)) ? INST_NW'(INST_DEPTH) : n;
  endfunction

endpackage

// File: rtl/ovl_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding array results until the host drains them.
module ovl_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/overlay_host_ctrl.sv
// Host sequencer for the PE-array overlay: instruction playback, batch feed, load strobe, result capture.
// Optional: define OVL_DRAIN_TIMEOUT_EN to abort a stalled DRAIN after TIMEOUT idle cycles and raise err.
module overlay_host_ctrl
  import overlay_host_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [INST_NW-1:0]    inst_num,
  input  logic                  inst_wr_en,
  input  logic [INST_AW-1:0]    inst_wr_addr,
  input  logic [INST_WIDTH-1:0] inst_wr_data,
  input  logic                  s_data_v,
  output logic                  s_data_rdy,
  input  logic [WORD_WIDTH-1:0] s_data,
  output logic                  ov_inst_v,
  output logic [INST_WIDTH-1:0] ov_inst,
  output logic                  ov_din_v,
  output logic [WORD_WIDTH-1:0] ov_din,
  output logic                  ov_alpha_v,
  output logic                  ov_load,
  input  logic                  ov_dout_v,
  input  logic [WORD_WIDTH-1:0] ov_dout,
  output logic                  m_v,
  input  logic                  m_rdy,
  output logic [WORD_WIDTH-1:0] m_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t                state;
  state_t                state_next;
  logic [INST_WIDTH-1:0] inst_mem [INST_DEPTH];
  logic [INST_NW-1:0]    inst_len;
  logic [INST_AW-1:0]    inst_cnt;
  logic [PE_CW-1:0]      feed_cnt;
  logic [PE_CW-1:0]      cap_cnt;
  logic [LAT_CW-1:0]     wait_cnt;
  logic                  fifo_empty;
  logic                  start_ok;
  logic                  inst_last;
  logic                  accept;
  logic                  feed_last;
  logic                  wait_last;
  logic                  capture;
  logic                  cap_last;
  logic                  timeout_hit;

`ifdef OVL_DRAIN_TIMEOUT_EN
  logic [TO_CW-1:0]      to_cnt;
  logic                  err_q;
`endif

  assign busy = (state != ST_IDLE);
  assign m_v  = ~fifo_empty;

  // Instruction buffer keeps its contents across reset; writes land only while idle.
  always_ff @(posedge clk) begin
    if (inst_wr_en && (state == ST_IDLE)) begin
      inst_mem[inst_wr_addr] <= inst_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    s_data_rdy  = 1'b0;
    ov_load     = 1'b0;
    start_ok    = 1'b0;
    inst_last   = 1'b0;
    accept      = 1'b0;
    feed_last   = 1'b0;
    wait_last   = 1'b0;
    capture     = 1'b0;
    cap_last    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      ST_IDLE: begin
        // A new batch may not start until the previous results are fully drained.
        if (start && fifo_empty) begin
          start_ok   = 1'b1;
          state_next = (inst_num == '0) ? ST_FEED : ST_INST;
        end
      end
      ST_INST: begin
        inst_last = ((INST_NW'(inst_cnt) + INST_NW'(1)) == inst_len);
        if (inst_last) begin
          state_next = ST_FEED;
        end
      end
      ST_FEED: begin
        s_data_rdy = 1'b1;
        accept     = s_data_v;
        feed_last  = s_data_v && (feed_cnt == PE_CW'(PE_NUM - 1));
        if (feed_last) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_last = (wait_cnt == LAT_CW'(COMPUTE_LAT - 1));
        if (wait_last) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        ov_load    = 1'b1;
        state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        capture  = ov_dout_v;
        cap_last = ov_dout_v && (cap_cnt == PE_CW'(PE_NUM - 1));
`ifdef OVL_DRAIN_TIMEOUT_EN
        timeout_hit = !ov_dout_v && (to_cnt == TO_CW'(TIMEOUT - 1));
`endif
        if (cap_last || timeout_hit) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered array-side outputs and the per-phase counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_len   <= '0;
      inst_cnt   <= '0;
      feed_cnt   <= '0;
      wait_cnt   <= '0;
      cap_cnt    <= '0;
      ov_inst_v  <= 1'b0;
      ov_inst    <= '0;
      ov_din_v   <= 1'b0;
      ov_din     <= '0;
      ov_alpha_v <= 1'b0;
      done       <= 1'b0;
    end else begin
      ov_inst_v  <= 1'b0;
      ov_din_v   <= 1'b0;
      ov_alpha_v <= 1'b0;
      done       <= cap_last | timeout_hit;
      if (start_ok) begin
        inst_len <= clamp_inst_num(inst_num);
        inst_cnt <= '0;
      end
      if (state == ST_INST) begin
        ov_inst_v <= 1'b1;
        ov_inst   <= inst_mem[inst_cnt];
        inst_cnt  <= inst_last ? '0 : inst_cnt + INST_AW'(1);
      end
      if (accept) begin
        ov_din_v   <= 1'b1;
        ov_din     <= s_data;
        ov_alpha_v <= (feed_cnt == '0);
        feed_cnt   <= feed_last ? '0 : feed_cnt + PE_CW'(1);
      end
      if (state == ST_WAIT) begin
        wait_cnt <= wait_last ? '0 : wait_cnt + LAT_CW'(1);
      end
      if (cap_last || timeout_hit) begin
        cap_cnt <= '0;
      end else if (capture) begin
        cap_cnt <= cap_cnt + PE_CW'(1);
      end
    end
  end

`ifdef OVL_DRAIN_TIMEOUT_EN
  // Idle-cycle counter restarts on every captured word; err stays set until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if ((state != ST_DRAIN) || capture || timeout_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TO_CW'(1);
      end
      if (timeout_hit) begin
        err_q <= 1'b1;
      end
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  ovl_result_fifo #(
    .DEPTH (PE_NUM),
    .WIDTH (WORD_WIDTH)
  ) u_result_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (ov_dout),
    .pop       (m_rdy),
    .pop_data  (m_data),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_overlay_host_ctrl.sv
// Scenario-driven bench for overlay_host_ctrl with scoreboard queues for fed words and results.
module tb_overlay_host_ctrl;

  localparam int PE  = 8;
  localparam int LAT = 12;
  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  inst_num = '0;
  logic        inst_wr_en = 1'b0;
  logic [3:0]  inst_wr_addr = '0;
  logic [31:0] inst_wr_data = '0;
  logic        s_data_v = 1'b0;
  logic        s_data_rdy;
  logic [31:0] s_data = '0;
  logic        ov_inst_v;
  logic [31:0] ov_inst;
  logic        ov_din_v;
  logic [31:0] ov_din;
  logic        ov_alpha_v;
  logic        ov_load;
  logic        ov_dout_v = 1'b0;
  logic [31:0] ov_dout = '0;
  logic        m_v;
  logic        m_rdy = 1'b0;
  logic [31:0] m_data;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  logic [31:0] din_q [$];
  logic [31:0] res_q [$];

  always #5 clk = ~clk;

  overlay_host_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .inst_num     (inst_num),
    .inst_wr_en   (inst_wr_en),
    .inst_wr_addr (inst_wr_addr),
    .inst_wr_data (inst_wr_data),
    .s_data_v     (s_data_v),
    .s_data_rdy   (s_data_rdy),
    .s_data       (s_data),
    .ov_inst_v    (ov_inst_v),
    .ov_inst      (ov_inst),
    .ov_din_v     (ov_din_v),
    .ov_din       (ov_din),
    .ov_alpha_v   (ov_alpha_v),
    .ov_load      (ov_load),
    .ov_dout_v    (ov_dout_v),
    .ov_dout      (ov_dout),
    .m_v          (m_v),
    .m_rdy        (m_rdy),
    .m_data       (m_data),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  task automatic write_inst(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    inst_wr_en = 1'b1; inst_wr_addr = a; inst_wr_data = d;
    @(negedge clk);
    inst_wr_en = 1'b0;
  endtask

  task automatic pulse_start(input logic [4:0] n);
    @(negedge clk);
    start = 1'b1; inst_num = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feeds PE words, checks din latency/alpha, optionally injects ov_dout_v in WAIT, checks load timing.
  task automatic feed_batch(input logic [31:0] base, input bit gaps, input bit spurious);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    int load_k = 0;
    bit expect_v = 1'b0;
    logic [31:0] exp_w;
    while (got < PE && cyc < 100) begin
      @(negedge clk);
      checks++;
      if (ov_din_v !== expect_v) begin
        errors++; $display("[TB] FAIL din_latency: ov_din_v=%b expected %b (cycle %0d)", ov_din_v, expect_v, cyc);
      end
      if (ov_din_v === 1'b1 && din_q.size() > 0) begin
        exp_w = din_q.pop_front();
        checks++;
        if (ov_din !== exp_w) begin
          errors++; $display("[TB] FAIL din_data: got %h expected %h", ov_din, exp_w);
        end
        checks++;
        if (ov_alpha_v !== ((got == 0) ? 1'b1 : 1'b0)) begin
          errors++; $display("[TB] FAIL alpha: got %b on word %0d", ov_alpha_v, got);
        end
        got++;
      end else begin
        checks++;
        if (ov_alpha_v !== 1'b0) begin
          errors++; $display("[TB] FAIL alpha_idle: got %b expected 0", ov_alpha_v);
        end
      end
      inst_wr_en   = (cyc == 1);
      inst_wr_addr = 4'd0;
      inst_wr_data = 32'hBAD0_BAD0;
      s_data_v = (sent < PE) && (!gaps || (cyc % 2 == 0));
      s_data   = base + 32'(sent);
      expect_v = s_data_v && s_data_rdy;
      if (expect_v) begin
        din_q.push_back(s_data);
        sent++;
      end
      cyc++;
    end
    s_data_v = 1'b0; inst_wr_en = 1'b0;
    checks++;
    if (got != PE) begin
      errors++; $display("[TB] FAIL feed_count: got %0d words expected %0d", got, PE);
    end
    for (int k = 1; k <= 30 && load_k == 0; k++) begin
      @(negedge clk);
      if (ov_load === 1'b1) load_k = k;
      ov_dout_v = spurious && (k >= 2) && (k <= 4);
      ov_dout   = 32'hDEAD_0000 + 32'(k);
    end
    ov_dout_v = 1'b0;
    checks++;
    if (load_k != LAT) begin
      errors++; $display("[TB] FAIL load_timing: ov_load after %0d cycles expected %0d", load_k, LAT);
    end
    checks++;
    if (m_v !== 1'b0) begin
      errors++; $display("[TB] FAIL spurious_capture: m_v=%b expected 0", m_v);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({s_data_rdy, ov_inst_v, ov_inst, ov_din_v, ov_din, ov_alpha_v, ov_load, m_v, m_data, busy, done, err} !== '0) begin
      errors++; $display("[TB] FAIL reset_outputs: some output nonzero (busy=%b m_v=%b rdy=%b)", busy, m_v, s_data_rdy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_inst_playback();
    logic [31:0] exp_i;
    write_inst(4'd0, 32'hA0);
    write_inst(4'd1, 32'hA1);
    write_inst(4'd2, 32'hA2);
    pulse_start(5'd3);
    for (int k = 0; k < 6 && ov_inst_v !== 1'b1; k++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      exp_i = 32'hA0 + 32'(i);
      checks++;
      if (ov_inst_v !== 1'b1 || ov_inst !== exp_i) begin
        errors++; $display("[TB] FAIL inst_word%0d: got v=%b %h expected %h", i, ov_inst_v, ov_inst, exp_i);
      end
      checks++;
      if (s_data_rdy !== ((i == 2) ? 1'b1 : 1'b0)) begin
        errors++; $display("[TB] FAIL inst_rdy%0d: s_data_rdy=%b", i, s_data_rdy);
      end
      @(negedge clk);
    end
    checks++;
    if (ov_inst_v !== 1'b0) begin
      errors++; $display("[TB] FAIL inst_end: ov_inst_v=%b expected 0", ov_inst_v);
    end
  endtask

  task automatic test_feed_gaps();
    feed_batch(32'd1, 1'b1, 1'b1);
  endtask

  task automatic test_drain_hold();
    m_rdy = 1'b0;
    for (int i = 0; i < PE; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
        errors++; $display("[TB] FAIL done_early: done=1 before word %0d", i);
      end
      ov_dout_v = 1'b1; ov_dout = 32'h100 + 32'(i);
      res_q.push_back(ov_dout);
    end
    @(negedge clk);
    ov_dout_v = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || m_v !== 1'b1) begin
      errors++; $display("[TB] FAIL drain_done: done=%b busy=%b m_v=%b expected 1 0 1", done, busy, m_v);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++; $display("[TB] FAIL done_width: done=%b expected 0", done);
    end
    pulse_start(5'd1);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ov_inst_v !== 1'b0) begin
      errors++; $display("[TB] FAIL start_gated: busy=%b ov_inst_v=%b expected 0 0", busy, ov_inst_v);
    end
    for (int k = 0; k < 20 && res_q.size() > 0; k++) begin
      @(negedge clk);
      if (m_v === 1'b1) begin
        checks++;
        if (m_data !== res_q[0]) begin
          errors++; $display("[TB] FAIL result_order: got %h expected %h", m_data, res_q[0]);
        end
        void'(res_q.pop_front());
      end
      m_rdy = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (m_v !== 1'b0 || res_q.size() != 0) begin
      errors++; $display("[TB] FAIL fifo_drained: m_v=%b left=%0d expected 0 0", m_v, res_q.size());
    end
    pulse_start(5'd0);
    checks++;
    if (busy !== 1'b1 || s_data_rdy !== 1'b1) begin
      errors++; $display("[TB] FAIL start_accept: busy=%b rdy=%b expected 1 1", busy, s_data_rdy);
    end
  endtask

  task automatic test_reset_mid_feed();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      s_data_v = 1'b1; s_data = 32'h55 + 32'(i);
    end
    @(negedge clk);
    s_data_v = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({s_data_rdy, ov_inst_v, ov_inst, ov_din_v, ov_din, ov_alpha_v, ov_load, m_v, m_data, busy, done, err} !== '0) begin
      errors++; $display("[TB] FAIL mid_reset_outputs: busy=%b rdy=%b din_v=%b", busy, s_data_rdy, ov_din_v);
    end
    @(negedge clk);
    rst = 1'b1;
    din_q.delete();
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    m_rdy = 1'b1;
    pulse_start(5'd2);
    for (int k = 0; k < 6 && ov_inst_v !== 1'b1; k++) @(negedge clk);
    checks++;
    if (ov_inst_v !== 1'b1 || ov_inst !== 32'hA0) begin
      errors++; $display("[TB] FAIL retained_inst0: got v=%b %h expected A0", ov_inst_v, ov_inst);
    end
    @(negedge clk);
    checks++;
    if (ov_inst_v !== 1'b1 || ov_inst !== 32'hA1) begin
      errors++; $display("[TB] FAIL retained_inst1: got v=%b %h expected A1", ov_inst_v, ov_inst);
    end
    feed_batch(32'h200, 1'b0, 1'b0);
    for (int i = 0; i < PE + 4; i++) begin
      @(negedge clk);
      if (m_v === 1'b1) begin
        checks++;
        if (res_q.size() == 0) begin
          errors++; $display("[TB] FAIL b2b_extra: unexpected word %h", m_data);
        end else begin
          if (m_data !== res_q[0]) begin
            errors++; $display("[TB] FAIL b2b_order: got %h expected %h", m_data, res_q[0]);
          end
          void'(res_q.pop_front());
        end
      end
      if (done === 1'b1) done_cnt++;
      ov_dout_v = (i < PE);
      ov_dout   = 32'h300 + 32'(i);
      if (i < PE) res_q.push_back(ov_dout);
    end
    ov_dout_v = 1'b0;
    checks++;
    if (res_q.size() != 0 || done_cnt != 1 || busy !== 1'b0 || m_v !== 1'b0) begin
      errors++; $display("[TB] FAIL b2b_end: left=%0d done_cnt=%0d busy=%b m_v=%b", res_q.size(), done_cnt, busy, m_v);
    end
  endtask

  task automatic test_clamp_and_timeout();
    int inst_cnt = 0;
    int err_k = 0;
    int done_cnt = 0;
    m_rdy = 1'b0;
    pulse_start(5'd20);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (ov_inst_v === 1'b1) inst_cnt++;
    end
    checks++;
    if (inst_cnt != 16) begin
      errors++; $display("[TB] FAIL inst_clamp: %0d instructions expected 16", inst_cnt);
    end
    feed_batch(32'h400, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ov_dout_v = 1'b1; ov_dout = 32'h500 + 32'(i);
      res_q.push_back(ov_dout);
    end
    for (int k = 1; k <= TMO + 20 && err_k == 0; k++) begin
      @(negedge clk);
      ov_dout_v = 1'b0;
      if (done === 1'b1) done_cnt++;
      if (err === 1'b1) err_k = k;
    end
`ifdef OVL_DRAIN_TIMEOUT_EN
    checks++;
    if (err_k != TMO + 1 || done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL timeout: err at %0d expected %0d done=%b busy=%b", err_k, TMO + 1, done, busy);
    end
    for (int k = 0; k < 12 && res_q.size() > 0; k++) begin
      @(negedge clk);
      if (m_v === 1'b1) begin
        checks++;
        if (m_data !== res_q[0]) begin
          errors++; $display("[TB] FAIL partial_order: got %h expected %h", m_data, res_q[0]);
        end
        void'(res_q.pop_front());
      end
      m_rdy = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (m_v !== 1'b0 || res_q.size() != 0 || err !== 1'b1) begin
      errors++; $display("[TB] FAIL partial_count: m_v=%b left=%0d err=%b", m_v, res_q.size(), err);
    end
`else
    checks++;
    if (err_k != 0 || done_cnt != 0 || busy !== 1'b1 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL no_timeout: err_k=%0d done_cnt=%0d busy=%b", err_k, done_cnt, busy);
    end
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_inst_playback();
    test_feed_gaps();
    test_drain_hold();
    test_reset_mid_feed();
    test_back_to_back();
    test_clamp_and_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/overlay_host_ctrl.md
Name: overlay_host_ctrl

Overview:
Host-side sequencer that drives the PE-array overlay and collects its results.
- Plays back a locally stored instruction program into the array.
- Streams one batch of PE_NUM input words into the array's serial-in buffer.
- Waits a fixed compute latency, pulses the array's parallel-load strobe, then captures the PE_NUM serial result words into a result FIFO drained by a ready/valid master port.

Parameters:
PE_NUM, 8, PEs in the array; words per batch in each direction
DATA_WIDTH, 16, half-word width; words are 2*DATA_WIDTH bits (complex I/Q)
INST_WIDTH, 32, instruction width
INST_DEPTH, 16, local instruction-buffer entries
COMPUTE_LAT, 12, cycles from last input word to the load pulse
TIMEOUT, 64, drain timeout cycles (only with the optional feature)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  one-cycle batch request
inst_num  in  clog2(INST_DEPTH)+1  instructions to play this batch
inst_wr_en  in  1  instruction-buffer write strobe
inst_wr_addr  in  clog2(INST_DEPTH)  write address
inst_wr_data  in  INST_WIDTH  write data
s_data_v  in  1  upstream word valid
s_data_rdy  out  1  upstream word ready
s_data  in  2*DATA_WIDTH  upstream word
ov_inst_v  out  1  instruction valid to the array
ov_inst  out  INST_WIDTH  instruction to the array
ov_din_v  out  1  serial input word valid to the array
ov_din  out  2*DATA_WIDTH  serial input word to the array
ov_alpha_v  out  1  alpha strobe to the array
ov_load  out  1  parallel-load strobe to the array's output buffer
ov_dout_v  in  1  serial result valid from the array
ov_dout  in  2*DATA_WIDTH  serial result from the array
m_v  out  1  result valid
m_rdy  in  1  result ready
m_data  out  2*DATA_WIDTH  result word
busy  out  1  FSM not in IDLE
done  out  1  one-cycle batch-complete pulse
err  out  1  sticky timeout flag (0 without the optional feature)

Behaviour:
- Reset (rst=0, asynchronous): FSM to IDLE; FIFO empty; all counters 0; every output 0.
- Instruction buffer:
  - Written only in IDLE; inst_wr_en is ignored while busy.
  - Contents are not cleared by reset.
- FSM states: IDLE, INST, FEED, WAIT, LOAD, DRAIN.
- IDLE -> INST on start=1 when the FIFO is empty. start is ignored while busy or while the FIFO is non-empty.
- At start, inst_num is latched and clamped to INST_DEPTH. If the latched value is 0, go straight to FEED.
- INST:
  - One instruction per cycle from address 0 upward; ov_inst_v=1 and ov_inst are registered.
  - After the last instruction, go to FEED.
- FEED:
  - s_data_rdy=1 only in this state.
  - Each accepted word (s_data_v & s_data_rdy) appears on ov_din/ov_din_v exactly 1 cycle later.
  - ov_alpha_v pulses together with the first ov_din_v of the batch.
  - After PE_NUM accepted words, go to WAIT. Gaps in s_data_v simply stall the state.
- WAIT: counts COMPUTE_LAT cycles starting after the last ov_din_v, then goes to LOAD.
- LOAD: ov_load=1 for exactly one cycle, then go to DRAIN.
- DRAIN:
  - Every ov_dout_v=1 cycle pushes ov_dout into the FIFO (depth PE_NUM; never overflows because start is gated on empty).
  - When the PE_NUM-th word is captured: done=1 for 1 cycle, FSM to IDLE.
- ov_dout_v outside DRAIN is ignored and not stored.
- FIFO output: m_v = non-empty; pop on m_v & m_rdy; first-word-fall-through; results come out in array output order. Draining may overlap IDLE.
- Push and pop in the same cycle are both honoured.
- Counters wrap only at their terminal values; no modular reuse.

Optional Feature:
OVL_DRAIN_TIMEOUT_EN
- Defined: a DRAIN cycle counter resets on each captured word. If it reaches TIMEOUT, err is set (sticky until reset), done pulses, and the FSM returns to IDLE. The partial words stay in the FIFO.
- Undefined: no counter; DRAIN waits indefinitely; err tied to 0.

Decomposition:
- Package overlay_host_pkg:
  - FSM state encoding (3-bit).
  - Word-width constant 2*DATA_WIDTH.
  - clog2-derived counter widths.
- One sub-module: ovl_result_fifo (synchronous FWFT FIFO, parameterised depth and width, async active-low reset).

Test Plan:
- Reset mid-FEED (rst low after 3 words) -> all outputs 0, busy=0, FIFO empty. A following batch runs normally.
- inst_num=3, buffer 0xA0..0xA2, start -> ov_inst_v high 3 consecutive cycles carrying 0xA0,0xA1,0xA2, then s_data_rdy=1.
- FEED with words 1..8, s_data_v low every other cycle -> ov_din 1..8 each 1 cycle after acceptance. ov_alpha_v only with word 1. ov_load exactly 12 cycles after the last ov_din_v.
- Array returns 8 results 0x100..0x107, m_rdy=0 -> done pulses after the 8th capture, FIFO full. A start issued now is ignored. Raising m_rdy yields 0x100..0x107 in order, then start accepted.
- Spurious ov_dout_v in WAIT -> not captured; FIFO count unchanged.
- With OVL_DRAIN_TIMEOUT_EN: only 5 results returned -> err=1 and done=1 64 cycles after the 5th capture, FIFO holds 5 words. Without the macro: FSM stays in DRAIN.
